seq_pipe_arb_2stage: RTL and testbench

SEQ_PIPE_ARB_2STAGE -- requirements
Module: seq_pipe_arb_2stage

---
 rtl/seq_pipe_arb_2stage.sv | 104 ++++++++++
 tb/tb_seq_pipe_arb_2stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pipe_arb_2stage.sv
// Two-requester round-robin arbiter feeding a two-stage valid/ready pipeline.
// S1 drives the output channel directly; S0 is refilled from the granted requester.
module seq_pipe_arb_2stage #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in0_val,
    output logic             in0_rdy,
    input  logic [NBITS-1:0] in0_data,
    input  logic             in1_val,
    output logic             in1_rdy,
    input  logic [NBITS-1:0] in1_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_data,
    output logic             out_tag,
    output logic [1:0]       occupancy
);

    logic             s0_vld_q, s0_vld_d;
    logic             s0_tag_q, s0_tag_d;
    logic [NBITS-1:0] s0_data_q, s0_data_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_tag_q, s1_tag_d;
    logic [NBITS-1:0] s1_data_q, s1_data_d;
    logic             ptr_q, ptr_d;

    logic s1_free;
    logic s0_free;
    logic any_req;
    logic gnt;
    logic accept;

    always_comb begin
        s1_free = !s1_vld_q || out_rdy;
        s0_free = !s0_vld_q || s1_free;
        any_req = in0_val || in1_val;
        // Pointer only matters under contention; a lone requester always wins.
        gnt     = (in0_val && in1_val) ? ptr_q : in1_val;
        accept  = any_req && s0_free && !flush;
    end

    // Gating with reset_n keeps both ready lines low while reset is held.
    assign in0_rdy = reset_n && accept && !gnt;
    assign in1_rdy = reset_n && accept && gnt;

    always_comb begin
        s0_vld_d  = s0_vld_q;
        s0_tag_d  = s0_tag_q;
        s0_data_d = s0_data_q;
        s1_vld_d  = s1_vld_q;
        s1_tag_d  = s1_tag_q;
        s1_data_d = s1_data_q;
        ptr_d     = ptr_q;
        if (flush) begin
            s0_vld_d = 1'b0;
            s1_vld_d = 1'b0;
        end else begin
            if (s1_free) begin
                s1_vld_d  = s0_vld_q;
                s1_tag_d  = s0_tag_q;
                s1_data_d = s0_data_q;
            end
            if (s0_free) begin
                s0_vld_d = accept;
                if (accept) begin
                    s0_tag_d  = gnt;
                    s0_data_d = gnt ? in1_data : in0_data;
                end
            end
            if (accept) begin
                ptr_d = !gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_vld_q  <= 1'b0;
            s0_tag_q  <= 1'b0;
            s0_data_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_tag_q  <= 1'b0;
            s1_data_q <= '0;
            ptr_q     <= 1'b0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_tag_q  <= s0_tag_d;
            s0_data_q <= s0_data_d;
            s1_vld_q  <= s1_vld_d;
            s1_tag_q  <= s1_tag_d;
            s1_data_q <= s1_data_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_val   = s1_vld_q;
    assign out_data  = s1_data_q;
    assign out_tag   = s1_tag_q;
    assign occupancy = {1'b0, s0_vld_q} + {1'b0, s1_vld_q};

endmodule

// File: tb/tb_seq_pipe_arb_2stage.sv
// Directed bench for seq_pipe_arb_2stage: reset, streaming, contention,
// backpressure, bubbles, flush and asynchronous reset.
module tb_seq_pipe_arb_2stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in0_val, in1_val;
    logic       in0_rdy, in1_rdy;
    logic [7:0] in0_data, in1_data;
    logic       out_val, out_rdy, out_tag;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    int total = 0;
    int bad   = 0;

    seq_pipe_arb_2stage #(.NBITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_data(in0_data),
        .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_data(in1_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_tag(out_tag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        in0_val = 1'b1; in0_data = 8'h5A; in1_val = 1'b1; in1_data = 8'hA5;
        step();
        step();
        total++;
        if (out_val !== 1'b0 || occupancy !== 2'd0 || out_data !== 8'h00 || out_tag !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out_val=%b occ=%0d data=%h tag=%b, want 0 0 00 0",
                     out_val, occupancy, out_data, out_tag);
        end
        total++;
        if (in0_rdy !== 1'b0 || in1_rdy !== 1'b0) begin
            bad++;
            $display("FAIL reset_rdy: in0_rdy=%b in1_rdy=%b, want 0 0", in0_rdy, in1_rdy);
        end
        in0_val = 1'b0; in1_val = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_contention();
        logic [7:0] n0, n1, exp_d;
        logic       exp_t;
        n0 = 8'h00; n1 = 8'h00;
        out_rdy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            in0_val = (k <= 4); in1_val = (k <= 4);
            in0_data = 8'hA0 + n0; in1_data = 8'hB0 + n1;
            #1;
            if (k <= 4) begin
                total++;
                if (in0_rdy !== ((k % 2) == 1) || in1_rdy !== ((k % 2) == 0)) begin
                    bad++;
                    $display("FAIL contention_grant k=%0d: in0_rdy=%b in1_rdy=%b, want grant to %0d",
                             k, in0_rdy, in1_rdy, (k + 1) % 2);
                end
                if (k % 2 == 1) n0++; else n1++;
            end
            step();
            if (k >= 2 && k <= 5) begin
                exp_t = 1'((k - 2) % 2);
                exp_d = (exp_t ? 8'hB0 : 8'hA0) + 8'((k - 2) / 2);
                total++;
                if (out_val !== 1'b1 || out_tag !== exp_t || out_data !== exp_d) begin
                    bad++;
                    $display("FAIL contention_out k=%0d: val=%b tag=%b data=%h, want 1 %b %h",
                             k, out_val, out_tag, out_data, exp_t, exp_d);
                end
            end else if (k == 6) begin
                total++;
                if (out_val !== 1'b0 || occupancy !== 2'd0) begin
                    bad++;
                    $display("FAIL contention_drain: val=%b occ=%0d, want 0 0", out_val, occupancy);
                end
            end
        end
    endtask

    task automatic test_single_stream();
        out_rdy = 1'b1; in1_val = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in0_val = (k <= 3);
            in0_data = 8'(k * 8'h11);
            #1;
            if (k <= 3) begin
                total++;
                if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_rdy k=%0d: in0_rdy=%b in1_rdy=%b, want 1 0", k, in0_rdy, in1_rdy);
                end
            end
            step();
            total++;
            if (k >= 2 && k <= 4) begin
                if (out_val !== 1'b1 || out_tag !== 1'b0 || out_data !== 8'((k - 1) * 8'h11)) begin
                    bad++;
                    $display("FAIL stream_out k=%0d: val=%b tag=%b data=%h, want 1 0 %h",
                             k, out_val, out_tag, out_data, 8'((k - 1) * 8'h11));
                end
            end else if (out_val !== 1'b0) begin
                bad++;
                $display("FAIL stream_gap k=%0d: val=%b, want 0", k, out_val);
            end
        end
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0; in1_val = 1'b0;
        in0_val = 1'b1; in0_data = 8'h51;
        step();
        in0_data = 8'h52;
        step();
        in0_data = 8'h53;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (occupancy !== 2'd2 || in0_rdy !== 1'b0 || in1_rdy !== 1'b0 ||
                out_val !== 1'b1 || out_data !== 8'h51) begin
                bad++;
                $display("FAIL backpressure_hold k=%0d: occ=%0d rdy=%b%b val=%b data=%h, want 2 00 1 51",
                         k, occupancy, in0_rdy, in1_rdy, out_val, out_data);
            end
            step();
        end
        in0_val = 1'b0; out_rdy = 1'b1;
        step();
        total++;
        if (out_val !== 1'b1 || out_data !== 8'h52 || occupancy !== 2'd1) begin
            bad++;
            $display("FAIL backpressure_release: val=%b data=%h occ=%0d, want 1 52 1",
                     out_val, out_data, occupancy);
        end
        step();
        total++;
        if (out_val !== 1'b0 || occupancy !== 2'd0) begin
            bad++;
            $display("FAIL backpressure_drain: val=%b occ=%0d, want 0 0", out_val, occupancy);
        end
    endtask

    task automatic test_bubble();
        logic       vin  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] eocc [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        logic       evld [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] edat [5] = '{8'h00, 8'h61, 8'h00, 8'h62, 8'h00};
        out_rdy = 1'b1; in1_val = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in0_val  = vin[k];
            in0_data = (k == 0) ? 8'h61 : 8'h62;
            step();
            total++;
            if (occupancy !== eocc[k] || out_val !== evld[k] ||
                (evld[k] && out_data !== edat[k])) begin
                bad++;
                $display("FAIL bubble k=%0d: occ=%0d val=%b data=%h, want %0d %b %h",
                         k, occupancy, out_val, out_data, eocc[k], evld[k], edat[k]);
            end
        end
    endtask

    task automatic test_flush();
        out_rdy = 1'b0; in1_val = 1'b0;
        in0_val = 1'b1; in0_data = 8'h71;
        step();
        in0_data = 8'h72;
        step();
        flush = 1'b1;
        in0_val = 1'b1; in0_data = 8'h73;
        in1_val = 1'b1; in1_data = 8'h83;
        #1;
        total++;
        if (occupancy !== 2'd2 || in0_rdy !== 1'b0 || in1_rdy !== 1'b0) begin
            bad++;
            $display("FAIL flush_rdy: occ=%0d rdy=%b%b, want 2 00", occupancy, in0_rdy, in1_rdy);
        end
        step();
        flush = 1'b0;
        total++;
        if (occupancy !== 2'd0 || out_val !== 1'b0) begin
            bad++;
            $display("FAIL flush_clear: occ=%0d val=%b, want 0 0", occupancy, out_val);
        end
        out_rdy = 1'b1;
        #1;
        total++;
        if (in0_rdy !== 1'b0 || in1_rdy !== 1'b1) begin
            bad++;
            $display("FAIL flush_pointer: rdy=%b%b, want 01", in0_rdy, in1_rdy);
        end
        step();
        in0_val = 1'b0; in1_val = 1'b0;
        step();
        total++;
        if (out_val !== 1'b1 || out_tag !== 1'b1 || out_data !== 8'h83) begin
            bad++;
            $display("FAIL flush_after: val=%b tag=%b data=%h, want 1 1 83", out_val, out_tag, out_data);
        end
        step();
    endtask

    task automatic test_async_reset();
        out_rdy = 1'b0; in1_val = 1'b0;
        in0_val = 1'b1; in0_data = 8'h91;
        step();
        in0_data = 8'h92;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_val !== 1'b0 || occupancy !== 2'd0 || out_data !== 8'h00 ||
            in0_rdy !== 1'b0 || in1_rdy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: val=%b occ=%0d data=%h rdy=%b%b, want 0 0 00 00",
                     out_val, occupancy, out_data, in0_rdy, in1_rdy);
        end
        in0_val = 1'b1; in0_data = 8'hC0;
        in1_val = 1'b1; in1_data = 8'hD0;
        out_rdy = 1'b1;
        step();
        reset_n = 1'b1;
        #1;
        total++;
        if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_grant: rdy=%b%b, want 10", in0_rdy, in1_rdy);
        end
        step();
        in0_val = 1'b0; in1_val = 1'b0;
        step();
        total++;
        if (out_val !== 1'b1 || out_tag !== 1'b0 || out_data !== 8'hC0) begin
            bad++;
            $display("FAIL async_reset_out: val=%b tag=%b data=%h, want 1 0 C0", out_val, out_tag, out_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

endmodule
